sr_controller: RTL and testbench

Instruction register, decoder and control FSM that sequences the 16-bit register-file/shifter/ALU datapath one instruction at a time. It sits between the instruction source and the datapath. It captures an instruction, then drives every datapath control input cycle by cycle, including the immediate on `datapath_in`, until the result is written back. It raises `w` when idle.

---
 rtl/sr_controller.sv | 133 +++++++++++++
 tb/tb_sr_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_controller.sv
// Instruction register, decoder and Moore control FSM for the 16-bit regfile/shifter/ALU datapath.
// Latency: 1-5 cycles with w low per instruction; load/s honoured only in WAIT, with w as the ready indication.
module sr_controller (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        s,
   input  logic [15:0] instr,
   output logic        w,
   output logic        illegal,
   output logic [15:0] datapath_in,
   output logic        wb_sel,
   output logic        w_en,
   output logic        en_A,
   output logic        en_B,
   output logic        en_C,
   output logic        en_status,
   output logic        sel_A,
   output logic        sel_B,
   output logic [2:0]  w_addr,
   output logic [2:0]  r_addr,
   output logic [1:0]  shift_op,
   output logic [1:0]  ALU_op
);

   typedef enum logic [2:0] {
      S_WAIT, S_DECODE, S_WRITE_IMM, S_LOAD_A, S_LOAD_B, S_CALC, S_WRITE_RD
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] ir;

   logic [2:0] opcode, rn, rd, rm;
   logic [1:0] op, sh;
   logic       is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

   assign opcode = ir[15:13];
   assign op     = ir[12:11];
   assign rn     = ir[10:8];
   assign rd     = ir[7:5];
   assign sh     = ir[4:3];
   assign rm     = ir[2:0];

   assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
   assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
   assign is_alu     = (opcode == 3'b101);
   assign is_cmp     = is_alu && (op == 2'b01);
   assign is_mvn     = is_alu && (op == 2'b11);

   assign datapath_in = {{8{ir[7]}}, ir[7:0]};

   // IR only moves in WAIT, so it stays frozen for the whole instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_WAIT;
         ir    <= 16'h0000;
      end else begin
         state <= state_nxt;
         if (load && (state == S_WAIT))
            ir <= instr;
      end
   end

   always_comb begin
      state_nxt = state;
      w         = 1'b0;
      illegal   = 1'b0;
      wb_sel    = 1'b0;
      w_en      = 1'b0;
      en_A      = 1'b0;
      en_B      = 1'b0;
      en_C      = 1'b0;
      en_status = 1'b0;
      sel_A     = 1'b0;
      sel_B     = 1'b0;
      w_addr    = rd;
      r_addr    = rm;
      shift_op  = sh;
      ALU_op    = is_alu ? op : 2'b00;

      case (state)
         S_WAIT: begin
            w = 1'b1;
            if (s)
               state_nxt = S_DECODE;
         end
         S_DECODE: begin
            if (is_mov_imm)
               state_nxt = S_WRITE_IMM;
            else if (is_mov_reg || is_mvn)
               state_nxt = S_LOAD_B;
            else if (is_alu)
               state_nxt = S_LOAD_A;
            else begin
               illegal   = 1'b1;
               state_nxt = S_WAIT;
            end
         end
         S_WRITE_IMM: begin
            w_addr    = rn;
            wb_sel    = 1'b1;
            w_en      = 1'b1;
            state_nxt = S_WAIT;
         end
         S_LOAD_A: begin
            r_addr    = rn;
            en_A      = 1'b1;
            state_nxt = S_LOAD_B;
         end
         S_LOAD_B: begin
            en_B      = 1'b1;
            state_nxt = S_CALC;
         end
         S_CALC: begin
            // MOV reg zeroes the A operand so the ALU add passes the shifted Rm through.
            sel_A = is_mov_reg;
            if (is_cmp) begin
               en_status = 1'b1;
               state_nxt = S_WAIT;
            end else begin
               en_C      = 1'b1;
               state_nxt = S_WRITE_RD;
            end
         end
         S_WRITE_RD: begin
            w_en      = 1'b1;
            state_nxt = S_WAIT;
         end
         default: state_nxt = S_WAIT;
      endcase
   end

endmodule

// File: tb/tb_sr_controller.sv
// Directed bench for sr_controller with a small behavioural datapath attached.
module tb_sr_controller;

   logic        clk = 1'b0;
   logic        rst_n, load, s;
   logic [15:0] instr;
   logic        w, illegal, wb_sel, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B;
   logic [15:0] datapath_in;
   logic [2:0]  w_addr, r_addr;
   logic [1:0]  shift_op, ALU_op;

   int err_cnt = 0;
   int chk_cnt = 0;

   always #5 clk = ~clk;

   sr_controller dut (
      .clk(clk), .rst_n(rst_n), .load(load), .s(s), .instr(instr),
      .w(w), .illegal(illegal), .datapath_in(datapath_in),
      .wb_sel(wb_sel), .w_en(w_en), .en_A(en_A), .en_B(en_B), .en_C(en_C),
      .en_status(en_status), .sel_A(sel_A), .sel_B(sel_B),
      .w_addr(w_addr), .r_addr(r_addr), .shift_op(shift_op), .ALU_op(ALU_op)
   );

   logic [4:0] ens;
   assign ens = {w_en, en_A, en_B, en_C, en_status};

   // Behavioural datapath: register file, A/B/C registers, shifter, ALU, zero flag.
   logic [15:0] rf [8];
   logic [15:0] ra, rb, rc, sh_b, alu_a, alu_y;
   logic        z_flag;

   always_comb begin
      case (shift_op)
         2'b00:   sh_b = rb;
         2'b01:   sh_b = {rb[14:0], 1'b0};
         2'b10:   sh_b = {1'b0, rb[15:1]};
         default: sh_b = {rb[15], rb[15:1]};
      endcase
      alu_a = sel_A ? 16'h0000 : ra;
      case (ALU_op)
         2'b00:   alu_y = alu_a + sh_b;
         2'b01:   alu_y = alu_a - sh_b;
         2'b10:   alu_y = alu_a & sh_b;
         default: alu_y = ~sh_b;
      endcase
   end

   always @(posedge clk) begin
      if (w_en)      rf[w_addr] <= wb_sel ? datapath_in : rc;
      if (en_A)      ra <= rf[r_addr];
      if (en_B)      rb <= rf[r_addr];
      if (en_C)      rc <= alu_y;
      if (en_status) z_flag <= (alu_y == 16'h0000);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Loads the IR in one WAIT cycle, then pulses s; returns with the DUT in DECODE.
   task automatic issue(input logic [15:0] i);
      instr = i;
      load  = 1'b1;
      step();
      load  = 1'b0;
      s     = 1'b1;
      step();
      s     = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; load = 1'b0; s = 1'b0; instr = 16'h0000;
      #1;
      check("rst_w", w, 1);
      check("rst_illegal", illegal, 0);
      check("rst_ens", ens, 0);
      check("rst_dpin", datapath_in, 16'h0000);
      step(); step();
      rst_n = 1'b1;
      step();
      check("post_rst_w", w, 1);

      // MOV R0,#7
      issue(16'hD007);
      check("movi_dec_w", w, 0);
      check("movi_dec_ens", ens, 0);
      step();
      check("movi_wr_ens", ens, 5'b10000);
      check("movi_wr_addr", w_addr, 0);
      check("movi_wr_sel", wb_sel, 1);
      check("movi_dpin", datapath_in, 16'h0007);
      check("movi_wr_w", w, 0);
      step();
      check("movi_done_w", w, 1);
      check("movi_r0", rf[0], 16'h0007);

      // MOV R1,#-2
      issue(16'hD1FE);
      check("movn_dpin", datapath_in, 16'hFFFE);
      step(); step();
      check("movn_r1", rf[1], 16'hFFFE);

      // ADD R2,R1,R0,LSL#1
      issue(16'hA148);
      check("add_c1_w", w, 0);
      step();
      check("add_la_w", w, 0);
      check("add_la_raddr", r_addr, 1);
      check("add_la_ens", ens, 5'b01000);
      step();
      check("add_lb_w", w, 0);
      check("add_lb_raddr", r_addr, 0);
      check("add_lb_ens", ens, 5'b00100);
      step();
      check("add_calc_w", w, 0);
      check("add_calc_aluop", ALU_op, 2'b00);
      check("add_calc_shop", shift_op, 2'b01);
      check("add_calc_ens", ens, 5'b00010);
      check("add_calc_selA", sel_A, 0);
      step();
      check("add_wr_w", w, 0);
      check("add_wr_addr", w_addr, 2);
      check("add_wr_ens", ens, 5'b10000);
      check("add_wr_sel", wb_sel, 0);
      step();
      check("add_done_w", w, 1);
      check("add_r2", rf[2], 16'h000C);

      // CMP R0,R1
      issue(16'hA801);
      check("cmp_dec_ens", ens, 0);
      step();
      check("cmp_la_ens", ens, 5'b01000);
      check("cmp_la_raddr", r_addr, 0);
      step();
      check("cmp_lb_ens", ens, 5'b00100);
      check("cmp_lb_raddr", r_addr, 1);
      step();
      check("cmp_calc_w", w, 0);
      check("cmp_calc_aluop", ALU_op, 2'b01);
      check("cmp_calc_ens", ens, 5'b00001);
      step();
      check("cmp_done_w", w, 1);
      check("cmp_zflag", z_flag, 0);
      check("cmp_r2_kept", rf[2], 16'h000C);

      // MVN R3,R0, with a load attempted during LOAD_B
      issue(16'hB860);
      step();
      check("mvn_lb_ens", ens, 5'b00100);
      check("mvn_lb_raddr", r_addr, 0);
      instr = 16'hE000;
      load  = 1'b1;
      step();
      load  = 1'b0;
      check("mvn_calc_aluop", ALU_op, 2'b11);
      check("mvn_calc_ens", ens, 5'b00010);
      check("mvn_ir_kept", datapath_in, 16'h0060);
      step();
      check("mvn_wr_addr", w_addr, 3);
      check("mvn_wr_ens", ens, 5'b10000);
      step();
      check("mvn_done_w", w, 1);
      check("mvn_r3", rf[3], 16'hFFF8);

      // MOV R6,R1
      issue(16'hC0C1);
      step();
      check("movr_lb_ens", ens, 5'b00100);
      step();
      check("movr_calc_selA", sel_A, 1);
      check("movr_calc_aluop", ALU_op, 2'b00);
      step(); step();
      check("movr_done_w", w, 1);
      check("movr_r6", rf[6], 16'hFFFE);

      // Illegal encoding
      issue(16'hE000);
      check("ill_dec_illegal", illegal, 1);
      check("ill_dec_ens", ens, 0);
      check("ill_dec_w", w, 0);
      step();
      check("ill_done_w", w, 1);
      check("ill_done_illegal", illegal, 0);

      // load and s together in WAIT: MOV R4,#5 must run, not the old IR
      instr = 16'hD405; load = 1'b1; s = 1'b1;
      step();
      load = 1'b0; s = 1'b0;
      check("ls_dec_dpin", datapath_in, 16'h0005);
      step();
      check("ls_wr_ens", ens, 5'b10000);
      check("ls_wr_addr", w_addr, 4);
      step();
      check("ls_r4", rf[4], 16'h0005);

      // s held high: MOV R5,#1 repeats with one WAIT cycle in between
      instr = 16'hD501; load = 1'b1; s = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("hold_w_%0d", i), w, (i % 3 == 2) ? 1 : 0);
         step();
      end
      s = 1'b0;
      step(); step(); step();
      check("hold_idle_w", w, 1);

      // Reset asserted mid-cycle during CALC of an ADD
      issue(16'hA148);
      step(); step(); step();
      check("rstc_calc_ens", ens, 5'b00010);
      #2 rst_n = 1'b0;
      #1;
      check("rstc_async_w", w, 1);
      check("rstc_async_ens", ens, 0);
      check("rstc_async_dpin", datapath_in, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("rstc_hold_ens_%0d", i), ens, 0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("rstc_after_w_%0d", i), w, 1);
         check($sformatf("rstc_after_ens_%0d", i), ens, 0);
      end
      check("rstc_r2_kept", rf[2], 16'h000C);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
